// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and data access (D).
// D wins contention until starveCnt_q reaches STARVE_MAX, which forces one I grant.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rdy,
  output logic [DATA_W-1:0] i_data,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_rdy,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_re,
  output logic              m_we,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy,
  output logic              grant_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          latCnt_q, latCnt_d;
  logic [3:0]          starveCnt_q, starveCnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                isWrite_q, isWrite_d;
  logic                owner_q, owner_d;
  logic                mRe_q, mRe_d;
  logic                mWe_q, mWe_d;
  logic [DATA_W-1:0]   iData_q, iData_d;
  logic [DATA_W-1:0]   dData_q, dData_d;
  logic                dPend;
  logic                forceI;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      latCnt_q    <= '0;
      starveCnt_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      isWrite_q   <= 1'b0;
      owner_q     <= 1'b0;
      mRe_q       <= 1'b0;
      mWe_q       <= 1'b0;
      iData_q     <= '0;
      dData_q     <= '0;
    end else begin
      state_q     <= state_d;
      latCnt_q    <= latCnt_d;
      starveCnt_q <= starveCnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      isWrite_q   <= isWrite_d;
      owner_q     <= owner_d;
      mRe_q       <= mRe_d;
      mWe_q       <= mWe_d;
      iData_q     <= iData_d;
      dData_q     <= dData_d;
    end
  end

  assign dPend  = d_re | d_we;
  assign forceI = i_req && (starveCnt_q == STARVE_LIM);

  always_comb begin
    state_d     = state_q;
    latCnt_d    = latCnt_q;
    starveCnt_d = starveCnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    isWrite_d   = isWrite_q;
    owner_d     = owner_q;
    mRe_d       = 1'b0;
    mWe_d       = 1'b0;
    iData_d     = iData_q;
    dData_d     = dData_q;

    case (state_q)
      IDLE: begin
        // A simultaneous read+write request is served as a write.
        if (dPend && !forceI) begin
          owner_d   = 1'b1;
          addr_d    = d_addr;
          wdata_d   = d_wdata;
          isWrite_d = d_we;
          mRe_d     = ~d_we;
          mWe_d     = d_we;
          state_d   = ISSUE;
          if (i_req && (starveCnt_q < STARVE_LIM)) begin
            starveCnt_d = starveCnt_q + 4'd1;
          end
        end else if (i_req) begin
          owner_d     = 1'b0;
          addr_d      = i_addr;
          isWrite_d   = 1'b0;
          mRe_d       = 1'b1;
          starveCnt_d = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (isWrite_q) begin
          state_d = DONE;
        end else begin
          latCnt_d = LAT_INIT;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (latCnt_q == 4'd1) begin
          latCnt_d = '0;
          state_d  = DONE;
          if (owner_q) begin
            dData_d = m_rdata;
          end else begin
            iData_d = m_rdata;
          end
        end else begin
          latCnt_d = latCnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign i_rdy   = (state_q == DONE) && !owner_q;
  assign d_rdy   = (state_q == DONE) && owner_q;
  assign busy    = (state_q != IDLE);
  assign grant_d = owner_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;
  assign m_re    = mRe_q;
  assign m_we    = mWe_q;
  assign i_data  = iData_q;
  assign d_rdata = dData_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected memory strobes and ready
// pulses with their absolute cycle; a negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [15:0] i_addr = '0;
  logic        i_rdy;
  logic [15:0] i_data;
  logic        d_re = 1'b0;
  logic        d_we = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic        d_rdy;
  logic [15:0] d_rdata;
  logic [15:0] m_addr;
  logic        m_re;
  logic        m_we;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        busy;
  logic        grant_d;

  int assertCount = 0;
  int failCount = 0;
  int cyc = 0;
  int rdCycle = -1;
  logic [15:0] rdAddr = '0;
  logic [15:0] lastDRead = '0;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } expT;

  localparam int K_MRE = 1, K_MWE = 2, K_IRDY = 3, K_DRDY = 4;

  expT sbQ[$];

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_data(i_data),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdy(d_rdy), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memVal(logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  // Memory model: read data is valid only in the cycle MEM_LAT after the m_re cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_re) begin
      rdCycle <= cyc + MEM_LAT;
      rdAddr  <= m_addr;
    end
  end

  assign m_rdata = (cyc == rdCycle) ? memVal(rdAddr) : 16'hDEAD;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void pushExp(int kind, int c, logic [15:0] addr, logic [15:0] data);
    expT e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = addr;
    e.data = data;
    sbQ.push_back(e);
  endfunction

  task automatic applyStimulus(logic iReq, logic [15:0] iAddr, logic dRe, logic dWe,
                               logic [15:0] dAddr, logic [15:0] dWdata);
    i_req   = iReq;
    i_addr  = iAddr;
    d_re    = dRe;
    d_we    = dWe;
    d_addr  = dAddr;
    d_wdata = dWdata;
  endtask

  task automatic waitCycle(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic matchEvent(int kind, logic [15:0] addr, logic [15:0] data);
    expT e;
    if (sbQ.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL unexpected event kind=%0d at cycle %0d, nothing expected", kind, cyc);
    end else begin
      e = sbQ.pop_front();
      checkOutput("event kind", kind, e.kind);
      checkOutput("event cycle", cyc, e.cyc);
      if (kind == K_MRE || kind == K_MWE) checkOutput("m_addr", addr, e.addr);
      if (kind != K_MRE) checkOutput("event data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (sbQ.size() > 0 && sbQ[0].cyc < cyc) begin
        assertCount++;
        failCount++;
        $display("[TB] FAIL missed event kind=%0d: expected at cycle %0d, now %0d",
                 sbQ[0].kind, sbQ[0].cyc, cyc);
        void'(sbQ.pop_front());
      end
      if (m_re)  matchEvent(K_MRE, m_addr, 16'h0);
      if (m_we)  matchEvent(K_MWE, m_addr, m_wdata);
      if (i_rdy) matchEvent(K_IRDY, 16'h0, i_data);
      if (d_rdy) matchEvent(K_DRDY, 16'h0, d_rdata);
    end
  end

  initial begin
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset strobes", {m_re, m_we, i_rdy, d_rdy, grant_d}, 0);
    checkOutput("reset data", {m_addr, m_wdata, i_data, d_rdata}, 0);
    waitCycle(2);
    rst = 1'b0;

    // Isolated I read
    waitCycle(5);
    pushExp(K_MRE, 6, 16'h0010, 16'h0);
    pushExp(K_IRDY, 9, 16'h0, 16'hA5A5);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int k = 1; k <= 4; k++) begin
      waitCycle(5 + k);
      checkOutput("busy during I read", busy, 1);
    end
    i_req = 1'b0;
    waitCycle(10);
    checkOutput("busy after I read", busy, 0);

    // D write
    waitCycle(12);
    pushExp(K_MWE, 13, 16'h0200, 16'h1234);
    pushExp(K_DRDY, 14, 16'h0, lastDRead);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 16'h0200, 16'h1234);
    waitCycle(14);
    d_we = 1'b0;

    // Contention: D first, then I
    waitCycle(20);
    pushExp(K_MRE, 21, 16'h0300, 16'h0);
    pushExp(K_DRDY, 24, 16'h0, memVal(16'h0300));
    pushExp(K_MRE, 26, 16'h0030, 16'h0);
    pushExp(K_IRDY, 29, 16'h0, memVal(16'h0030));
    applyStimulus(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0300, 16'h0);
    waitCycle(22);
    checkOutput("grant_d contention D", grant_d, 1);
    waitCycle(24);
    d_re = 1'b0;
    lastDRead = memVal(16'h0300);
    waitCycle(27);
    checkOutput("grant_d contention I", grant_d, 0);
    waitCycle(29);
    i_req = 1'b0;

    // Starvation: four contested D grants, then I forced
    waitCycle(35);
    for (int k = 0; k < 4; k++) begin
      pushExp(K_MRE, 36 + 5 * k, 16'h0400 + 16'(k), 16'h0);
      pushExp(K_DRDY, 39 + 5 * k, 16'h0, memVal(16'h0400 + 16'(k)));
    end
    pushExp(K_MRE, 56, 16'h0040, 16'h0);
    pushExp(K_IRDY, 59, 16'h0, memVal(16'h0040));
    pushExp(K_MRE, 61, 16'h0404, 16'h0);
    pushExp(K_DRDY, 64, 16'h0, memVal(16'h0404));
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0400, 16'h0);
    for (int k = 0; k < 4; k++) begin
      waitCycle(39 + 5 * k);
      d_addr = 16'h0400 + 16'(k + 1);
    end
    waitCycle(57);
    checkOutput("grant_d forced I", grant_d, 0);
    waitCycle(59);
    i_req = 1'b0;
    waitCycle(62);
    checkOutput("grant_d after starve", grant_d, 1);
    waitCycle(64);
    d_re = 1'b0;
    lastDRead = memVal(16'h0404);

    // Reset during WAIT aborts the read with no d_rdy
    waitCycle(70);
    pushExp(K_MRE, 71, 16'h0500, 16'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0500, 16'h0);
    waitCycle(72);
    rst = 1'b1;
    d_re = 1'b0;
    #1;
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset strobes", {m_re, m_we, i_rdy, d_rdy, grant_d}, 0);
    checkOutput("mid reset data", {m_addr, m_wdata, i_data, d_rdata}, 0);
    lastDRead = 16'h0;
    waitCycle(74);
    rst = 1'b0;
    waitCycle(76);
    pushExp(K_MRE, 77, 16'h0600, 16'h0);
    pushExp(K_DRDY, 80, 16'h0, memVal(16'h0600));
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0600, 16'h0);
    waitCycle(80);
    d_re = 1'b0;
    lastDRead = memVal(16'h0600);

    // Dual strobe acts as a write and leaves d_rdata alone
    waitCycle(85);
    pushExp(K_MWE, 86, 16'h0700, 16'hBEEF);
    pushExp(K_DRDY, 87, 16'h0, lastDRead);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 16'h0700, 16'hBEEF);
    waitCycle(87);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

    waitCycle(95);
    checkOutput("d_rdata held", d_rdata, lastDRead);
    checkOutput("i_data held after reset", i_data, 0);
    checkOutput("idle at end", busy, 0);
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
